dmem_sync_param: RTL and testbench

Parametrised synchronous data memory for the RISC processor datapath. It is the successor to the fixed 1024×16 data memory and adds:
- configurable width and depth
- byte-lane write enables
- a registered read with a valid strobe
- out-of-range address detection
- an automatic zero-clear sweep after reset

It sits between the ALU/address path and the register-file write-back mux.

---
 rtl/dmem_sync_param_if.sv | 33 +++
 rtl/dmem_sync_param.sv | 142 ++++++++++++++
 tb/tb_dmem_sync_param.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_sync_param_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sync_param_if
// Description : Request/response bundle between the address path and the
//               parametrised data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_sync_param_if #(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 16
);
  logic                       regRead;
  logic                       regWrite;
  logic [ADDR_W-1:0]          dataInAdd;
  logic [DATA_W-1:0]          dataIn;
  logic [DATA_W/BYTE_W-1:0]   byteEn;
  logic [DATA_W-1:0]          dataOut;
  logic                       dataValid;
  logic                       addrErr;
  logic                       busy;

  modport master (
    output regRead, regWrite, dataInAdd, dataIn, byteEn,
    input  dataOut, dataValid, addrErr, busy
  );

  modport slave (
    input  regRead, regWrite, dataInAdd, dataIn, byteEn,
    output dataOut, dataValid, addrErr, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sync_param
// Description : Synchronous data memory with byte-lane writes, registered
//               read + valid, range check and post-reset zero-clear sweep.
//               Define DMEM_WR_BYPASS_EN for write-first same-cycle reads.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_sync_param #(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input wire                clock,
  input wire                reset_n,
  dmem_sync_param_if.slave  bus
);

  localparam int                  c_LANES     = DATA_W / BYTE_W;
  localparam int                  c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]     c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [c_IDX_W-1:0]   r_clrCnt;
  logic [c_IDX_W-1:0]   w_clrCntNext;

  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic [DATA_W-1:0]    r_dataOut;
  logic [DATA_W-1:0]    w_dataOutNext;
  logic                 r_dataValid;
  logic                 w_dataValidNext;
  logic                 r_addrErr;
  logic                 w_addrErrNext;

  logic                 w_inRange;
  logic [c_IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]    w_oldWord;
  logic [DATA_W-1:0]    w_mergeWord;
  logic [DATA_W-1:0]    w_rdWord;

  logic                 w_memWe;
  logic [c_IDX_W-1:0]   w_memAddr;
  logic [DATA_W-1:0]    w_memData;

  // Full-width compare so addresses beyond DEPTH never alias onto real words.
  assign w_inRange = ({1'b0, bus.dataInAdd} < c_DEPTH_EXT);
  assign w_idx     = bus.dataInAdd[c_IDX_W-1:0];
  assign w_oldWord = r_mem[w_idx];

  for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
    assign w_mergeWord[gi*BYTE_W +: BYTE_W] = bus.byteEn[gi]
                                            ? bus.dataIn[gi*BYTE_W +: BYTE_W]
                                            : w_oldWord[gi*BYTE_W +: BYTE_W];
  end

`ifdef DMEM_WR_BYPASS_EN
  assign w_rdWord = bus.regWrite ? w_mergeWord : w_oldWord;
`else
  assign w_rdWord = w_oldWord;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= CLEAR;
      r_clrCnt    <= '0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
      r_addrErr   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_clrCnt    <= w_clrCntNext;
      r_dataOut   <= w_dataOutNext;
      r_dataValid <= w_dataValidNext;
      r_addrErr   <= w_addrErrNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_clrCntNext    = r_clrCnt;
    w_dataOutNext   = r_dataOut;
    w_dataValidNext = 1'b0;
    w_addrErrNext   = 1'b0;
    w_memWe         = 1'b0;
    w_memAddr       = w_idx;
    w_memData       = w_mergeWord;

    case (r_state)
      CLEAR: begin
        w_memWe   = 1'b1;
        w_memAddr = r_clrCnt;
        w_memData = '0;
        if (r_clrCnt == c_LAST_IDX) begin
          w_stateNext  = READY;
          w_clrCntNext = '0;
        end else begin
          w_clrCntNext = r_clrCnt + c_IDX_W'(1);
        end
      end

      READY: begin
        if (bus.regWrite && w_inRange) begin
          w_memWe = 1'b1;
        end
        if (bus.regRead) begin
          w_dataValidNext = 1'b1;
          w_dataOutNext   = w_inRange ? w_rdWord : '0;
        end
        if ((bus.regRead || bus.regWrite) && !w_inRange) begin
          w_addrErrNext = 1'b1;
        end
      end

      default: begin
        w_stateNext = CLEAR;
      end
    endcase
  end

  // Array has no reset so it can map onto block RAM; the sweep zeroes it.
  always_ff @(posedge clock) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  assign bus.dataOut   = r_dataOut;
  assign bus.dataValid = r_dataValid;
  assign bus.addrErr   = r_addrErr;
  assign bus.busy      = (r_state == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_dmem_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_sync_param
// Description : Self-checking bench for dmem_sync_param: directed scenarios
//               plus randomized traffic against a behavioural memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_sync_param;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;

`ifdef DMEM_WR_BYPASS_EN
  localparam bit c_BYPASS = 1'b1;
`else
  localparam bit c_BYPASS = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  dmem_sync_param_if #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) bus ();

  dmem_sync_param #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int nVec = 0;
  int nMis = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: sweep is just a countdown of clock edges, memory is a plain array.
  bit [15:0]   mdl [DEPTH];
  int          clearLeft = DEPTH;
  bit [15:0]   expOut    = 16'h0000;
  bit          expValid  = 1'b0;
  bit          expErr    = 1'b0;
  int unsigned mAddr;
  bit          mIn;
  bit [15:0]   mMask;
  bit [15:0]   mNew;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clearLeft = DEPTH;
      expOut    = 16'h0000;
      expValid  = 1'b0;
      expErr    = 1'b0;
      foreach (mdl[i]) mdl[i] = 16'h0000;
    end else if (clearLeft > 0) begin
      clearLeft = clearLeft - 1;
      expValid  = 1'b0;
      expErr    = 1'b0;
    end else begin
      mAddr    = bus.dataInAdd;
      mIn      = (mAddr < DEPTH);
      expValid = bus.regRead;
      expErr   = (bus.regRead || bus.regWrite) && !mIn;
      if (mIn) begin
        mMask = {{8{bus.byteEn[1]}}, {8{bus.byteEn[0]}}};
        mNew  = (mdl[mAddr] & ~mMask) | (bus.dataIn & mMask);
        if (bus.regRead)  expOut = (c_BYPASS && bus.regWrite) ? mNew : mdl[mAddr];
        if (bus.regWrite) mdl[mAddr] = mNew;
      end else if (bus.regRead) begin
        expOut = 16'h0000;
      end
    end
  end

  always @(posedge clock) begin
    #2;
    check("busy",      bus.busy,      32'(clearLeft > 0));
    check("dataValid", bus.dataValid, 32'(expValid));
    check("addrErr",   bus.addrErr,   32'(expErr));
    check("dataOut",   bus.dataOut,   32'(expOut));
  end

  task automatic idle();
    bus.regRead   = 1'b0;
    bus.regWrite  = 1'b0;
    bus.dataInAdd = '0;
    bus.dataIn    = '0;
    bus.byteEn    = '0;
  endtask

  task automatic op(input bit rd, input bit wr, input int addr,
                    input logic [15:0] d, input logic [1:0] be);
    @(negedge clock);
    bus.regRead   = rd;
    bus.regWrite  = wr;
    bus.dataInAdd = 16'(addr);
    bus.dataIn    = d;
    bus.byteEn    = be;
    @(posedge clock);
    #2;
    idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    idle();
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy",  bus.busy,      32'd1);
    check("rst_out",   bus.dataOut,   32'h0);
    check("rst_valid", bus.dataValid, 32'd0);
    check("rst_err",   bus.addrErr,   32'd0);

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    // Requests during the sweep must be ignored.
    bus.regRead   = 1'b1;
    bus.regWrite  = 1'b1;
    bus.dataInAdd = 16'd5;
    bus.dataIn    = 16'hFFFF;
    bus.byteEn    = 2'b11;
    repeat (1000) @(posedge clock);
    #2 idle();
    repeat (23) @(posedge clock);
    #2 check("busy_at_1023", bus.busy, 32'd1);
    @(posedge clock);
    #2 check("busy_at_1024", bus.busy, 32'd0);

    op(1, 0, 370, 16'h0, 2'b00);
    check("rd370_clear",  bus.dataOut,   32'h0000);
    check("rd370_valid",  bus.dataValid, 32'd1);
    op(1, 0, 5, 16'h0, 2'b00);
    check("rd5_ignored",  bus.dataOut,   32'h0000);

    op(0, 1, 370, 16'd170, 2'b11);
    check("wr370_valid",  bus.dataValid, 32'd0);
    op(1, 0, 370, 16'h0, 2'b00);
    check("rd370",        bus.dataOut,   32'd170);
    @(posedge clock);
    #2 check("valid_one_cycle", bus.dataValid, 32'd0);

    op(0, 1, 590, 16'hD670, 2'b11);
    op(1, 0, 590, 16'h0, 2'b00);
    check("rd590",        bus.dataOut,   32'hD670);
    op(0, 1, 590, 16'hABCD, 2'b01);
    op(1, 0, 590, 16'h0, 2'b00);
    check("rd590_lane0",  bus.dataOut,   32'hD6CD);
    op(0, 1, 590, 16'hFFFF, 2'b00);
    op(1, 0, 590, 16'h0, 2'b00);
    check("rd590_be00",   bus.dataOut,   32'hD6CD);

    op(0, 1, 1024, 16'h1234, 2'b11);
    check("oor_wr_err",   bus.addrErr,   32'd1);
    check("oor_wr_valid", bus.dataValid, 32'd0);
    op(1, 0, 0, 16'h0, 2'b00);
    check("rd0_nowrap",   bus.dataOut,   32'h0000);
    check("rd0_err",      bus.addrErr,   32'd0);
    op(0, 1, 1023, 16'h0BEE, 2'b11);
    check("wr1023_err",   bus.addrErr,   32'd0);
    op(1, 0, 1024, 16'h0, 2'b00);
    check("oor_rd_out",   bus.dataOut,   32'h0000);
    check("oor_rd_valid", bus.dataValid, 32'd1);
    check("oor_rd_err",   bus.addrErr,   32'd1);
    op(1, 0, 65535, 16'h0, 2'b00);
    check("oor_max_err",  bus.addrErr,   32'd1);

    op(0, 1, 100, 16'h1111, 2'b11);
    op(1, 1, 100, 16'h2222, 2'b11);
    check("rw_same_addr", bus.dataOut,   c_BYPASS ? 32'h2222 : 32'h1111);
    op(1, 0, 100, 16'h0, 2'b00);
    check("rd100_after",  bus.dataOut,   32'h2222);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      r = $urandom_range(0, 15);
      if (r == 0)      bus.dataInAdd = 16'($urandom_range(1024, 65535));
      else if (r < 7)  bus.dataInAdd = 16'($urandom_range(0, 7));
      else if (r == 7) bus.dataInAdd = 16'd1023;
      else             bus.dataInAdd = 16'($urandom_range(0, 1023));
      bus.regRead  = 1'($urandom_range(0, 1));
      bus.regWrite = 1'($urandom_range(0, 1));
      bus.dataIn   = 16'($urandom);
      bus.byteEn   = 2'($urandom_range(0, 3));
    end
    @(negedge clock);
    idle();

    op(0, 1, 370, 16'd170, 2'b11);
    @(negedge clock);
    bus.regRead   = 1'b1;
    bus.dataInAdd = 16'd370;
    @(posedge clock);
    #2 check("pre_rst_valid", bus.dataValid, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.dataValid, 32'd0);
    check("mid_rst_out",   bus.dataOut,   32'h0000);
    check("mid_rst_busy",  bus.busy,      32'd1);
    idle();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (1024) @(posedge clock);
    #2 check("resweep_done", bus.busy, 32'd0);
    op(1, 0, 370, 16'h0, 2'b00);
    check("rd370_resweep", bus.dataOut,   32'h0000);
    check("rd370_rs_vld",  bus.dataValid, 32'd1);

    repeat (2) @(posedge clock);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire
